// File: rtl/ex_alu_seq_pkg.sv
// rtl/ex_alu_seq_pkg.sv - shared ALU opcode header
// Opcode width and encodings consumed by ex_alu_seq and c_alu.
package ex_alu_seq_pkg;

  localparam int ALUOP_L = 4;

  localparam logic [ALUOP_L-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_L-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_L-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_L-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUOP_L-1:0] ALU_XOR = 4'd4;
  localparam logic [ALUOP_L-1:0] ALU_SLL = 4'd5;
  localparam logic [ALUOP_L-1:0] ALU_SRL = 4'd6;
  localparam logic [ALUOP_L-1:0] ALU_SLT = 4'd7;

endpackage

// File: rtl/ex_alu_seq.sv
// rtl/ex_alu_seq.sv - sequencer issuing decoded requests to c_alu over a run/ack handshake
// Holds operands stable for the whole run/ack exchange and guards it with a sticky timeout.
module ex_alu_seq
  import ex_alu_seq_pkg::*;
#(
  parameter int OPR_L = 32,
  parameter int TMO_L = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_L-1:0] in_op,
  input  logic [OPR_L-1:0]   in_rs1,
  input  logic [OPR_L-1:0]   in_rs2,
  input  logic [OPR_L-1:0]   in_imm,
  input  logic [OPR_L-1:0]   in_pc,
  input  logic               in_sel_pc,
  input  logic               in_sel_imm,
  input  logic               in_c,
  input  logic [4:0]         in_rd,
  output logic               alu_run,
  output logic [ALUOP_L-1:0] alu_op,
  output logic [OPR_L-1:0]   alu_A,
  output logic [OPR_L-1:0]   alu_B,
  output logic               alu_c,
  input  logic [OPR_L-1:0]   alu_Y,
  input  logic               alu_ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPR_L-1:0]   out_Y,
  output logic [4:0]         out_rd,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    DROP     = 3'd3,
    OUT      = 3'd4
  } state_t;

  localparam logic [TMO_L-1:0] TMO_MAX = '1;

  state_t           state, state_nx;
  logic [TMO_L-1:0] cnt;
  logic             cnt_last;
  logic             timeout;

  // The cycle on which cnt_last is seen is the (2^TMO_L-1)-th counted cycle.
  assign cnt_last = (cnt == TMO_MAX - TMO_L'(1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nx = ISSUE;
      end
      // A stale ack left over from a previous exchange must clear before run goes up.
      ISSUE: begin
        if (!alu_ack) state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (alu_ack) begin
          state_nx = DROP;
        end else if (cnt_last) begin
          timeout  = 1'b1;
          state_nx = OUT;
        end
      end
      DROP: begin
        if (!alu_ack) begin
          state_nx = OUT;
        end else if (cnt_last) begin
          timeout  = 1'b1;
          state_nx = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err     <= 1'b0;
      alu_run <= 1'b0;
      alu_op  <= '0;
      alu_A   <= '0;
      alu_B   <= '0;
      alu_c   <= 1'b0;
      out_Y   <= '0;
      out_rd  <= '0;
    end else begin
      state <= state_nx;

      if (state_nx != state) begin
        cnt <= '0;
      end else if (state == WAIT_ACK || state == DROP) begin
        cnt <= cnt + TMO_L'(1);
      end

      // The alu_* outputs are the holding registers; they only load at acceptance.
      if (state == IDLE && in_valid) begin
        alu_op <= in_op;
        alu_A  <= in_sel_pc ? in_pc : in_rs1;
        alu_B  <= in_sel_imm ? in_imm : in_rs2;
        alu_c  <= in_c;
        out_rd <= in_rd;
      end

      alu_run <= (state_nx == WAIT_ACK);

      if (timeout) begin
        out_Y <= '0;
        err   <= 1'b1;
      end else if (state == WAIT_ACK && alu_ack) begin
        out_Y <= alu_Y;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_seq.sv
// tb/tb_ex_alu_seq.sv - scoreboard bench for ex_alu_seq with a behavioural c_alu stand-in
module tb_ex_alu_seq;
  import ex_alu_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_L-1:0] in_op;
  logic [31:0]        in_rs1, in_rs2, in_imm, in_pc;
  logic               in_sel_pc, in_sel_imm, in_c;
  logic [4:0]         in_rd;
  logic               alu_run;
  logic [ALUOP_L-1:0] alu_op;
  logic [31:0]        alu_A, alu_B;
  logic               alu_c;
  logic [31:0]        alu_Y;
  logic               alu_ack;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_Y;
  logic [4:0]         out_rd;
  logic               err;

  ex_alu_seq #(.OPR_L(32), .TMO_L(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .in_sel_pc(in_sel_pc), .in_sel_imm(in_sel_imm), .in_c(in_c), .in_rd(in_rd),
    .alu_run(alu_run), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B), .alu_c(alu_c),
    .alu_Y(alu_Y), .alu_ack(alu_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_Y(out_Y), .out_rd(out_rd),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  rd;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend, e_mon;
  bit   pend_want;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   push_cnt = 0;
  int   obs_cnt = 0;
  bit   ack_en = 1'b1;
  bit   force_ack = 1'b0;
  logic run_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [ALUOP_L-1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // c_alu stand-in: ack follows run within the cycle and lingers one cycle after run falls.
  always @(negedge clk) begin
    alu_ack = force_ack | (ack_en & (alu_run | run_d));
    alu_Y   = (alu_run | run_d) ? alu_f(alu_op, alu_A, alu_B) : 32'hDEAD_BEEF;
    run_d   = alu_run;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      obs_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got Y=%h rd=%0d err=%b, required no output", out_Y, out_rd, err);
      end else begin
        e_mon = exp_q.pop_front();
        if (out_Y !== e_mon.y || out_rd !== e_mon.rd || err !== e_mon.e) begin
          errors++;
          $display("FAIL out_result: got Y=%h rd=%0d err=%b, required Y=%h rd=%0d err=%b",
                   out_Y, out_rd, err, e_mon.y, e_mon.rd, e_mon.e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic present(input logic [ALUOP_L-1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic sp, input logic si,
                         input logic c, input logic [4:0] rd, input logic [31:0] y, input logic e,
                         input bit want);
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
    in_sel_pc = sp; in_sel_imm = si; in_c = c; in_rd = rd;
    in_valid = 1'b1;
    pend.y = y; pend.rd = rd; pend.e = e;
    pend_want = want;
  endtask

  task automatic await_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        ok = 1'b1;
        acc_cyc = cyc + 1;
        if (pend_want) begin
          exp_q.push_back(pend);
          push_cnt++;
        end
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_accept: got no acceptance in 100 cycles, required acceptance", name);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_valid: got no out_valid in 100 cycles, required out_valid", name);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok = (obs_cnt >= push_cnt);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (obs_cnt >= push_cnt) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_done: got %0d outputs, required %0d", name, obs_cnt, push_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of run by 300us, required $finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad;
    int runs;
    bit run_seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0;
    in_sel_pc = 1'b0; in_sel_imm = 1'b0; in_c = 1'b0; in_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_alu_run", {31'd0, alu_run}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_Y", out_Y, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_alu_A", alu_A, 32'd0);
    chk("rst_alu_B", alu_B, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD 5+7, minimum latency
    present(ALU_ADD, 32'd5, 32'd7, 32'd99, 32'h40, 1'b0, 1'b0, 1'b0, 5'd3, 32'd12, 1'b0, 1'b1);
    await_accept("add");
    wait_valid("add");
    lat = cyc - acc_cyc;
    chk("add_latency", lat, 32'd4);
    wait_done("add");

    // SUB pc-imm with operand stability across the exchange
    present(ALU_SUB, 32'h55, 32'h66, 32'h4, 32'h100, 1'b1, 1'b1, 1'b1, 5'd9, 32'hFC, 1'b0, 1'b1);
    await_accept("sub");
    bad = 0; run_seen = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(negedge clk);
      if (alu_run) run_seen = 1'b1;
      if (!out_valid && (alu_A !== 32'h100 || alu_B !== 32'h4 || alu_op !== ALU_SUB || alu_c !== 1'b1)) bad++;
    end
    chk("sub_run_seen", {31'd0, run_seen}, 32'd1);
    chk("sub_operand_stable", bad, 32'd0);
    wait_done("sub");

    // Backpressure in OUT with a second request pending
    out_ready = 1'b0;
    present(ALU_ADD, 32'h1000, 32'h234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd17, 32'h1234, 1'b0, 1'b1);
    await_accept("hold1");
    wait_valid("hold1");
    @(posedge clk); #1;
    present(ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd4, 32'd3, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_Y", out_Y, 32'h1234);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("hold_out_rd", {27'd0, out_rd}, 32'd17);
    @(posedge clk); #1;
    out_ready = 1'b1;
    await_accept("hold2");
    wait_done("hold2");

    // Stale ack at entry: run must wait for ack to fall; result from fresh ack
    force_ack = 1'b1;
    present(ALU_ADD, 32'd20, 32'd22, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd5, 32'd42, 1'b0, 1'b1);
    await_accept("stale");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stale_run_low", {31'd0, alu_run}, 32'd0);
    end
    @(posedge clk); #1;
    force_ack = 1'b0;
    wait_done("stale");

    // Ack never arrives: timeout after 15 cycles in WAIT_ACK
    ack_en = 1'b0;
    present(ALU_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd7, 32'd0, 1'b1, 1'b1);
    await_accept("tmo");
    runs = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(negedge clk);
      if (alu_run) runs++;
    end
    chk("tmo_run_cycles", runs, 32'd15);
    chk("tmo_run_low", {31'd0, alu_run}, 32'd0);
    chk("tmo_err", {31'd0, err}, 32'd1);
    wait_done("tmo");

    // Reset while waiting for ack abandons the request
    present(ALU_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd2, 32'd2, 1'b0, 1'b0);
    await_accept("rst");
    run_seen = 1'b0;
    for (int i = 0; i < 20 && !run_seen; i++) begin
      @(negedge clk);
      if (alu_run) run_seen = 1'b1;
    end
    chk("rstmid_run_seen", {31'd0, run_seen}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_run", {31'd0, alu_run}, 32'd0);
    chk("rstmid_err", {31'd0, err}, 32'd0);
    chk("rstmid_idle", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstmid_no_valid", {31'd0, out_valid}, 32'd0);
    end
    ack_en = 1'b1;

    // Normal operation after reset
    @(posedge clk); #1;
    present(ALU_ADD, 32'd100, 32'd23, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd31, 32'd123, 1'b0, 1'b1);
    await_accept("post");
    wait_done("post");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_seq.md
EX_ALU_SEQ -- requirements
Module: ex_alu_seq

Interface
REQ-001 Parameter OPR_L, default 32, operand/result width.
REQ-002 Parameter TMO_L, default 4, width of ack-timeout counter (timeout = 2^TMO_L-1 cycles).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  decoded ALU request present.
REQ-006 in_ready  out  1  request accepted when in_valid&in_ready.
REQ-007 in_op  in  ALUOP_L  ALU opcode.
REQ-008 in_rs1, in_rs2, in_imm, in_pc  in  OPR_L  operand sources.
REQ-009 in_sel_pc  in  1  A=in_pc else in_rs1; in_sel_imm  in  1  B=in_imm else in_rs2.
REQ-010 in_c  in  1  ALU carry/invert bit; in_rd  in  5  destination register.
REQ-011 alu_run  out  1; alu_op  out  ALUOP_L; alu_A, alu_B  out  OPR_L; alu_c  out  1 -- drive the ALU (c_alu).
REQ-012 alu_Y  in  OPR_L; alu_ack  in  1 -- ALU result and acknowledge.
REQ-013 out_valid  out  1; out_ready  in  1; out_Y  out  OPR_L; out_rd  out  5 -- writeback handshake.
REQ-014 err  out  1  sticky ack-timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, DROP, OUT.
REQ-016 IDLE: in_ready=1; on in_valid capture op, selected A/B, c, rd into holding registers, go ISSUE.
REQ-017 ISSUE: alu_op/A/B/c stable from holding regs; alu_run rises on the ISSUE-to-WAIT_ACK edge, never in the same cycle operands change.
REQ-018 WAIT_ACK: alu_run=1; on alu_ack=1 capture alu_Y into out_Y, deassert alu_run, go DROP.
REQ-019 DROP: alu_run=0; wait for alu_ack=0, then go OUT; out_Y SHALL NOT be recaptured.
REQ-020 OUT: out_valid=1, out_Y/out_rd held; on out_ready go IDLE (in_ready=0 in OUT; no overlap).
REQ-021 Minimum latency, acceptance to out_valid: 4 cycles with ack returned 1 cycle after run and dropped 1 cycle after run falls.
REQ-022 alu_op/A/B/c SHALL remain constant from ISSUE until leaving DROP.
REQ-023 Timeout counter counts cycles in WAIT_ACK or DROP; at 2^TMO_L-1 set err=1, force alu_run=0, emit out_Y=0 in OUT.
REQ-024 err cleared only by rst; counter clears on each state entry.
REQ-025 alu_ack high in IDLE/ISSUE (stale) SHALL be ignored; ISSUE waits until alu_ack=0 before raising run.
REQ-026 in_valid while busy: in_ready=0, request not consumed, no state change.
REQ-027 out_ready high while not OUT: ignored.

Reset
REQ-028 On rst (sampled at clk): state=IDLE, alu_run=0, alu_op/A/B/c=0, out_valid=0, out_Y=0, out_rd=0, err=0, counter=0, in_ready=0 during the rst cycle.
REQ-029 rst mid-operation SHALL abandon the request without emitting out_valid; alu_run low the next cycle.

Structure
REQ-030 ALUOP_L and ALU opcode constants SHALL come from the shared ALU opcode header; no local redefinition.
REQ-031 FSM state encodings SHALL be local constants; single module, no sub-modules; paired with c_alu at top level.

Verification
REQ-032 op=ALU_ADD, rs1=5, rs2=7, sel_imm=0, ack model 1-cycle -> out_valid after 4 cycles, out_Y=12, out_rd echoed.
REQ-033 op=ALU_SUB, sel_pc=1, pc=0x100, sel_imm=1, imm=0x4 -> out_Y=0xFC; alu_A/alu_B stable throughout run.
REQ-034 ack never asserted -> err=1 after 15 cycles in WAIT_ACK, alu_run=0, out_Y=0, out_valid=1.
REQ-035 out_ready held 0 for 10 cycles in OUT -> out_valid, out_Y held; second in_valid not accepted until handshake.
REQ-036 rst asserted in WAIT_ACK -> next cycle alu_run=0, state IDLE, no out_valid pulse, err=0.
REQ-037 alu_ack stuck high at request entry -> run not raised until ack falls; result from the fresh ack only.
